buzzer_tone_gen: RTL and testbench
==================================

# buzzer_tone_gen

Square-wave tone generator for the passive buzzer. It accepts one note at a time over a valid/ready handshake. Each note is a half-period-derived cycle count, as produced by the note-to-period lookup stage directly upstream, plus a duration in milliseconds. It drives a 50 % duty square wave for that duration, then an optional silent inter-note gap. It sits between the score sequencer/lookup and the buzzer pin.

## Interface
- `CLK_FRE`, 50: clock frequency in MHz; one ms = `CLK_FRE*1000` clocks.
- `GAP_MS`, 10: silent gap after each note, ms (used only with gap feature compiled in).
- `DUR_W`, 12: width of duration field.
- `clk` in 1: system clock; one clock domain.
- `rst` in 1: synchronous, active-high reset.
- `note_valid` in 1: note request.
- `note_ready` out 1: block can accept a note.
- `note_cycle` in 20: clocks per tone period; 0 or 1 = rest (silence).
- `note_ms` in `DUR_W`: tone duration, ms; 0 = no tone phase.
- `buzzer` out 1: square-wave output to pin.
- `busy` out 1: high in TONE and GAP.
- `note_done` out 1: single-cycle pulse when a note (incl. gap) completes.

## Operation
- States: IDLE, TONE, GAP.
- IDLE → TONE on accept (`note_valid & note_ready` at a rising edge). This latches `note_cycle` and `note_ms` and clears the period counter, ms prescaler and ms counter.
  - If the latched `note_ms==0`, go IDLE → GAP directly.
- TONE: period counter `pcnt` runs 0..cycle-1 and wraps.
  - `buzzer=1` iff `pcnt < cycle>>1`; otherwise 0.
  - Odd cycle: high `floor(c/2)`, low `ceil(c/2)`.
  - Latched cycle < 2: buzzer held 0 for the whole phase (rest).
- Ms prescaler counts 0..`CLK_FRE*1000-1`. Each wrap increments the ms counter.
- TONE → GAP (or → IDLE without gap feature) when the ms counter reaches `note_ms` at a prescaler wrap.
  - The tone ends mid-period if needed, and buzzer is forced 0 from the first non-TONE cycle.
- GAP: buzzer 0 for exactly `GAP_MS*CLK_FRE*1000` clocks, then → IDLE.
- Entering IDLE from a note: `note_done` pulses for 1 cycle and `note_ready` is 1 in that same cycle. A back-to-back note may be accepted on that edge.
- `note_ready` is 1 only in IDLE; inputs are ignored outside IDLE.
- Reset (any state, any cycle): state IDLE, all counters 0, latched note cleared. No `note_done` is generated for an aborted note.

## Timing
- All outputs registered.
- Reset values: `buzzer=0`, `note_ready=0`, `busy=0`, `note_done=0`.
- `note_ready` rises at the first edge with `rst` low.
- Accept edge = cycle 0:
  - TONE occupies cycles 1..`note_ms*CLK_FRE*1000`. Buzzer in TONE cycle k (k from 0) follows the rule above using `pcnt=k mod cycle`.
  - `busy` is high from cycle 1 through the last GAP cycle.
  - `note_ready` is 0 from cycle 1.
- `note_done` and `note_ready` are both high in the cycle after the last TONE/GAP cycle.
- Counter widths: `pcnt` 20 bits, prescaler ≥17 bits at CLK_FRE=100, ms counter `DUR_W` bits. No overflow is possible for legal inputs.

## Configuration
- `BUZZER_TONE_GAP_EN` defined: GAP state present. The sequence is TONE → GAP → IDLE, and `note_ms==0` goes straight to GAP.
- Not defined: GAP state and `GAP_MS` logic removed. The sequence is TONE → IDLE, and `note_ms==0` returns to IDLE immediately with `note_done` in cycle 1.

## Test plan
All with `CLK_FRE=1`, `GAP_MS=2`, gap enabled unless stated.
- Reset release: buzzer/busy/done stay 0; `note_ready`=1 one cycle after `rst` falls.
- Accept `note_cycle=200`, `note_ms=3` at cycle 0:
  - buzzer gives 15 periods of 100 high/100 low over cycles 1..3000;
  - low over 3001..5000;
  - `note_done`+`note_ready` at 5001; busy 1..5000.
- `note_cycle=201`, `note_ms=1`: each period 100 high, 101 low; at cycle 1000 the period is truncated; buzzer 0 at 1001.
- `note_cycle=0`, `note_ms=2`, then `note_ms=0` back-to-back on the `note_done` edge:
  - first note: buzzer 0 throughout, done at 4001;
  - second note: GAP only, done 2001 cycles later.
- Assert `rst` at cycle 1500 of a 3 ms note: buzzer 0 and busy 0 next cycle; no `note_done`; `note_ready` 1 after release.
- Gap disabled, `note_cycle=200`, `note_ms=1`: `note_done` at 1001; `note_ms=0` gives `note_done` at cycle 1.

Source files
------------

// File: rtl/buzzer_tone_gen_if.sv
// Note request channel from the score sequencer/lookup stage into the tone generator.
interface buzzer_tone_gen_if #(
    parameter int DUR_W = 12
);
    logic             note_valid;
    logic             note_ready;
    logic [19:0]      note_cycle;
    logic [DUR_W-1:0] note_ms;

    modport master (output note_valid, output note_cycle, output note_ms, input note_ready);
    modport slave  (input note_valid, input note_cycle, input note_ms, output note_ready);
endinterface

// File: rtl/buzzer_tone_gen.sv
// Square-wave buzzer driver: one note per valid/ready accept, registered outputs, ready only in IDLE.
// Define BUZZER_TONE_GAP_EN to add a GAP_MS silent gap after every note.
module buzzer_tone_gen #(
    parameter int CLK_FRE = 50,
    parameter int GAP_MS  = 10,
    parameter int DUR_W   = 12
) (
    input  logic                clk,
    input  logic                rst,
    buzzer_tone_gen_if.slave    note,
    output logic                buzzer,
    output logic                busy,
    output logic                note_done
);
    localparam int unsigned      MS_CLKS = CLK_FRE * 1000;
    localparam int               PW      = $clog2(MS_CLKS);
    localparam logic [PW-1:0]    PRE_MAX = PW'(MS_CLKS - 1);
    localparam logic [DUR_W-1:0] ONE     = DUR_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TONE = 2'd1;
`ifdef BUZZER_TONE_GAP_EN
    localparam logic [1:0]       S_GAP    = 2'd2;
    localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_MS - 1);
`endif

    logic [1:0]       state;
    logic [19:0]      cyc_l;
    logic [DUR_W-1:0] ms_l;
    logic [19:0]      pcnt;
    logic [19:0]      pcnt_nxt;
    logic [PW-1:0]    presc;
    logic [DUR_W-1:0] mscnt;
    logic             accept;
    logic             pre_wrap;

    assign accept   = note.note_valid & note.note_ready;
    assign pre_wrap = (presc == PRE_MAX);

    // Cycle values 0 and 1 wrap every clock; half is then 0, so the buzzer stays low.
    always_comb begin
        pcnt_nxt = pcnt + 20'd1;
        if (pcnt_nxt >= cyc_l)
            pcnt_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            cyc_l           <= '0;
            ms_l            <= '0;
            pcnt            <= '0;
            presc           <= '0;
            mscnt           <= '0;
            buzzer          <= 1'b0;
            busy            <= 1'b0;
            note_done       <= 1'b0;
            note.note_ready <= 1'b0;
        end else begin
            note_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    note.note_ready <= 1'b1;
                    if (accept) begin
                        cyc_l <= note.note_cycle;
                        ms_l  <= note.note_ms;
                        pcnt  <= '0;
                        presc <= '0;
                        mscnt <= '0;
                        if (note.note_ms != '0) begin
                            state           <= S_TONE;
                            busy            <= 1'b1;
                            note.note_ready <= 1'b0;
                            buzzer          <= (note.note_cycle >= 20'd2);
                        end else begin
`ifdef BUZZER_TONE_GAP_EN
                            state           <= S_GAP;
                            busy            <= 1'b1;
                            note.note_ready <= 1'b0;
`else
                            note_done       <= 1'b1;
`endif
                        end
                    end
                end
                S_TONE: begin
                    pcnt   <= pcnt_nxt;
                    buzzer <= (pcnt_nxt < (cyc_l >> 1));
                    if (pre_wrap) begin
                        presc <= '0;
                        mscnt <= mscnt + ONE;
                        if ((mscnt + ONE) == ms_l) begin
                            buzzer <= 1'b0;
                            mscnt  <= '0;
`ifdef BUZZER_TONE_GAP_EN
                            state  <= S_GAP;
`else
                            state           <= S_IDLE;
                            busy            <= 1'b0;
                            note_done       <= 1'b1;
                            note.note_ready <= 1'b1;
`endif
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
`ifdef BUZZER_TONE_GAP_EN
                S_GAP: begin
                    buzzer <= 1'b0;
                    if (pre_wrap) begin
                        presc <= '0;
                        mscnt <= mscnt + ONE;
                        if (mscnt == GAP_LAST) begin
                            mscnt           <= '0;
                            state           <= S_IDLE;
                            busy            <= 1'b0;
                            note_done       <= 1'b1;
                            note.note_ready <= 1'b1;
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
`endif
                default: begin
                    state  <= S_IDLE;
                    buzzer <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Directed bench for buzzer_tone_gen at CLK_FRE=1, GAP_MS=2; expectations follow the gap build option.
module tb_buzzer_tone_gen;
    localparam int CLK_FRE = 1;
    localparam int GAP_MS  = 2;
    localparam int DUR_W   = 12;
`ifdef BUZZER_TONE_GAP_EN
    localparam int GAP_CYC = 2000;
`else
    localparam int GAP_CYC = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic buzzer, busy, note_done;

    buzzer_tone_gen_if #(.DUR_W(DUR_W)) nif ();

    buzzer_tone_gen #(.CLK_FRE(CLK_FRE), .GAP_MS(GAP_MS), .DUR_W(DUR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .note      (nif),
        .buzzer    (buzzer),
        .busy      (busy),
        .note_done (note_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // cyc, ms, tone cycles, total high cycles, rising edges (hand computed)
    typedef struct {
        int cyc;
        int ms;
        int tone_cyc;
        int exp_high;
        int exp_rises;
    } vec_t;

    vec_t vecs[7];

    task automatic run_note(input int idx);
        vec_t v;
        int total, bz_err, busy_err, hs_err, high, rises, done_at;
        logic prev, exp_bz;
        v        = vecs[idx];
        total    = v.tone_cyc + GAP_CYC + 1;
        bz_err   = 0; busy_err = 0; hs_err = 0;
        high     = 0; rises = 0; done_at = -1; prev = 1'b0;
        check($sformatf("v%0d ready_before_accept", idx), int'(nif.note_ready), 1);
        nif.note_cycle = 20'(v.cyc);
        nif.note_ms    = DUR_W'(v.ms);
        nif.note_valid = 1'b1;
        @(posedge clk);
        #1 nif.note_valid = 1'b0;
        for (int t = 1; t <= total; t++) begin
            @(negedge clk);
            exp_bz = (t <= v.tone_cyc) && (v.cyc >= 2) && (((t - 1) % v.cyc) < (v.cyc / 2));
            if (buzzer !== exp_bz) bz_err++;
            if (busy !== (t < total)) busy_err++;
            if ((note_done !== (t == total)) || (nif.note_ready !== (t == total))) hs_err++;
            if (buzzer === 1'b1) begin
                high++;
                if (prev == 1'b0) rises++;
            end
            prev = buzzer;
            if (note_done === 1'b1 && done_at < 0) done_at = t;
        end
        check($sformatf("v%0d buzzer_wave_mismatches", idx), bz_err, 0);
        check($sformatf("v%0d busy_mismatches", idx), busy_err, 0);
        check($sformatf("v%0d done_ready_mismatches", idx), hs_err, 0);
        check($sformatf("v%0d high_cycles", idx), high, v.exp_high);
        check($sformatf("v%0d rising_edges", idx), rises, v.exp_rises);
        check($sformatf("v%0d done_cycle", idx), done_at, v.tone_cyc + GAP_CYC + 1);
    endtask

    initial begin
        int dones, busys;
        vecs[0] = '{200, 3, 3000, 1500, 15};
        vecs[1] = '{201, 1, 1000,  500,  5};
        vecs[2] = '{  0, 2, 2000,    0,  0};
        vecs[3] = '{200, 0,    0,    0,  0};
        vecs[4] = '{  7, 1, 1000,  429, 143};
        vecs[5] = '{  1, 1, 1000,    0,  0};
        vecs[6] = '{200, 1, 1000,  500,  5};

        nif.note_valid = 1'b0;
        nif.note_cycle = '0;
        nif.note_ms    = '0;

        // Reset held: everything low, including ready
        repeat (3) @(negedge clk);
        check("rst_buzzer", int'(buzzer), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(note_done), 0);
        check("rst_ready", int'(nif.note_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check("release_ready", int'(nif.note_ready), 1);
        check("release_buzzer", int'(buzzer), 0);
        check("release_busy", int'(busy), 0);
        check("release_done", int'(note_done), 0);

        // Back-to-back notes, each issued on the previous note_done cycle
        for (int i = 0; i < 7; i++) run_note(i);

        // Abort a 3 ms note at cycle 1500
        nif.note_cycle = 20'd200;
        nif.note_ms    = DUR_W'(3);
        nif.note_valid = 1'b1;
        @(posedge clk);
        #1 nif.note_valid = 1'b0;
        repeat (1500) @(negedge clk);
        check("abort_buzzer_before", int'(buzzer), 1);
        check("abort_busy_before", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_buzzer", int'(buzzer), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(note_done), 0);
        check("abort_ready", int'(nif.note_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready_after", int'(nif.note_ready), 1);
        dones = 0;
        busys = 0;
        for (int t = 0; t < 6000; t++) begin
            @(negedge clk);
            if (note_done !== 1'b0) dones++;
            if (busy !== 1'b0) busys++;
        end
        check("abort_no_done", dones, 0);
        check("abort_stays_idle", busys, 0);

        // Normal operation resumes after the abort
        run_note(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
